fp_seq_divider: RTL and testbench
=================================

Name: fp_seq_divider

Overview:
- Multi-cycle IEEE-754 single-precision divider (z = a / b). It is the inverse operation of the team's combinational float multiplier.
- It sits beside the multiplier in the floating-point matrix datapath and uses a valid/ready handshake on both input and output.
- It uses radix-2 restoring mantissa division: one quotient bit per clock.
- Denormals are flushed to zero; rounding is round-to-nearest-even.

Parameters:
- EXP_W, 8, exponent width.
- FRAC_W, 23, stored fraction width. The bias is 2^(EXP_W-1)-1. The operand width is 1+EXP_W+FRAC_W.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands present.
- in_ready  output  1  divider can accept operands.
- a  input  32  dividend, IEEE-754.
- b  input  32  divisor, IEEE-754.
- out_valid  output  1  result held on output_z.
- out_ready  input  1  consumer takes the result.
- output_z  output  32  quotient, IEEE-754.
- out_flags  output  4  {invalid, div_by_zero, overflow, underflow}.

Behaviour:
- Reset, asynchronous: state=IDLE, in_ready=1, out_valid=0, output_z=0, out_flags=0. All internal registers are cleared.
- Reset mid-operation aborts the division. No result is emitted.

States: IDLE, UNPACK, DIVIDE, ROUND, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready (the accept edge E0), register a and b, then go to UNPACK.
- UNPACK (1 cycle):
  - Classify operands. exp=0 counts as zero, including denormals. exp=all-ones with frac!=0 is NaN; with frac=0 it is inf.
  - Sign = sa^sb.
  - Special cases go to DONE at E1.
  - Otherwise: ma={1,fa}, mb={1,fb}, e=ea-eb+bias. If ma<mb, set ma<<=1 and e-=1. Go to DIVIDE.
- DIVIDE:
  - Produce FRAC_W+3 quotient bits, MSB first (26 by default): integer bit, FRAC_W fraction bits, guard bit, round bit.
  - Each cycle: if rem>=mb, set rem=rem-mb and q bit=1. Then rem<<=1.
  - After the last bit, go to ROUND.
- ROUND (1 cycle):
  - sticky = (remainder != 0).
  - Round to nearest even using guard, round and sticky.
  - If rounding carries the mantissa to 2.0, shift right and set e+=1.
  - e >= 2^EXP_W-1: result is signed inf, overflow flag set.
  - e <= 0: result is signed zero, underflow flag set.
  - Go to DONE.
- DONE: out_valid=1; output_z and out_flags are held stable. On out_ready, go to IDLE and set out_valid=0 on that edge.
- in_ready=1 only in IDLE. It is 0 from the accept edge until the cycle after the output handshake, so there is no same-cycle turnaround. in_valid asserted while busy is ignored.

Latency, counted in edges after E0:
- Specials: out_valid after E1.
- Normal operands: out_valid after E(FRAC_W+5), which is E28 by default.
- Latency is fixed and does not depend on the data.

Special-case priority (highest first), with the flag set:
1. Either operand NaN → 7FC00000 (canonical NaN), invalid.
2. 0/0 or inf/inf → 7FC00000, invalid.
3. inf/finite → signed inf.
4. finite/inf → signed zero.
5. 0/nonzero → signed zero.
6. nonzero/0 → signed inf, div_by_zero.

Additional rules:
- Output sign for zero and inf results is sa^sb.
- out_flags are cleared at each accept.

Test Plan:
- 41700000/40400000 (15/3) → output_z=40A00000 after E28, flags 0. in_ready stays low for the whole operation.
- C20C0000/40E00000 (-35/7) → C0A00000. 3F800000/40400000 (1/3) → 3EAAAAAB, which checks RNE rounding up.
- 40A00000/00000000 → 7F800000 with div_by_zero, valid after E1. 00000000/00000000 → 7FC00000 with invalid. 7FC00001/3F800000 → 7FC00000 with invalid.
- 7F000000/00800000 → 7F800000 with overflow. 00800000/40000000 → 00000000 with underflow. 80000000/40000000 → 80000000.
- Hold out_ready low for 5 cycles in DONE → output_z and flags stable, in_ready=0. in_valid pulsed during DIVIDE is ignored. After the handshake, the next operand pair is accepted with in_ready=1.
- Assert rst at DIVIDE cycle 10 → out_valid=0 and in_ready=1 immediately. A fresh 15/3 afterwards gives 40A00000 with full latency.

Source files
------------

// File: rtl/fp_seq_divider.sv
// Multi-cycle IEEE-754 divider: radix-2 restoring mantissa division, one quotient bit per clock,
// flush-to-zero denormals, round-to-nearest-even, valid/ready on both sides.
module fp_seq_divider #(
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned FRAC_W = 23
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [EXP_W+FRAC_W:0]     a,
    input  logic [EXP_W+FRAC_W:0]     b,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [EXP_W+FRAC_W:0]     output_z,
    output logic [3:0]                out_flags
);
    localparam int unsigned OP_W  = 1 + EXP_W + FRAC_W;
    localparam int unsigned QW    = FRAC_W + 3;
    localparam int unsigned CNT_W = $clog2(QW);
    localparam int unsigned EW    = EXP_W + 2;
    localparam int unsigned BIAS  = (1 << (EXP_W - 1)) - 1;
    localparam int unsigned EMAX  = (1 << EXP_W) - 1;

    typedef enum logic [2:0] {IDLE, UNPACK, DIVIDE, ROUND, DONE} state_t;

    state_t             state_q;
    logic [OP_W-1:0]    a_q, b_q, z_q;
    logic [3:0]         flags_q;
    logic               in_ready_q, out_valid_q, sign_q;
    logic [QW-1:0]      rem_q, quo_q;
    logic [FRAC_W:0]    mb_q;
    logic [EW-1:0]      exp_q;
    logic [CNT_W-1:0]   cnt_q;

    // Operand classification (exp==0 is zero, denormals included)
    logic [EXP_W-1:0]   ea, eb;
    logic [FRAC_W-1:0]  fa, fb;
    logic               a_zero, b_zero, a_nan, b_nan, a_inf, b_inf, sign_d;
    assign ea     = a_q[OP_W-2 -: EXP_W];
    assign eb     = b_q[OP_W-2 -: EXP_W];
    assign fa     = a_q[FRAC_W-1:0];
    assign fb     = b_q[FRAC_W-1:0];
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_nan  = (&ea) && (|fa);
    assign b_nan  = (&eb) && (|fb);
    assign a_inf  = (&ea) && !(|fa);
    assign b_inf  = (&eb) && !(|fb);
    assign sign_d = a_q[OP_W-1] ^ b_q[OP_W-1];

    logic [OP_W-1:0] nan_c, inf_c, zero_c;
    assign nan_c  = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
    assign inf_c  = {sign_d, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    assign zero_c = {sign_d, {(EXP_W+FRAC_W){1'b0}}};

    logic            spec_hit;
    logic [OP_W-1:0] spec_z;
    logic [3:0]      spec_f;
    always_comb begin
        spec_hit = 1'b1;
        spec_z   = nan_c;
        spec_f   = 4'b0000;
        if (a_nan || b_nan) begin
            spec_f = 4'b1000;
        end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_f = 4'b1000;
        end else if (a_inf) begin
            spec_z = inf_c;
        end else if (b_inf || a_zero) begin
            spec_z = zero_c;
        end else if (b_zero) begin
            spec_z = inf_c;
            spec_f = 4'b0100;
        end else begin
            spec_hit = 1'b0;
        end
    end

    // Pre-normalise so the first quotient bit is always the integer 1
    logic [FRAC_W:0] ma_d, mb_d;
    logic            ma_lt;
    logic [QW-1:0]   rem_init;
    logic [EW-1:0]   exp_d;
    assign ma_d     = {1'b1, fa};
    assign mb_d     = {1'b1, fb};
    assign ma_lt    = (ma_d < mb_d);
    assign rem_init = ma_lt ? {1'b0, ma_d, 1'b0} : {2'b00, ma_d};
    assign exp_d    = EW'(ea) - EW'(eb) + EW'(BIAS) - EW'(ma_lt);

    logic [QW-1:0] mb_ext, rem_diff, rem_shift;
    logic          rem_ge;
    assign mb_ext    = {2'b00, mb_q};
    assign rem_ge    = (rem_q >= mb_ext);
    assign rem_diff  = rem_ge ? (rem_q - mb_ext) : rem_q;
    assign rem_shift = {rem_diff[QW-2:0], 1'b0};

    // RNE on {mantissa, guard, round} with the leftover remainder as sticky
    logic              rnd_up, carry, ovf, unf;
    logic [FRAC_W+1:0] mant_rnd;
    logic [FRAC_W-1:0] frac_rnd;
    logic [EW-1:0]     exp_rnd;
    assign rnd_up   = quo_q[1] & (quo_q[0] | (|rem_q) | quo_q[2]);
    assign mant_rnd = {1'b0, quo_q[QW-1:2]} + (FRAC_W+2)'(rnd_up);
    assign carry    = mant_rnd[FRAC_W+1];
    assign frac_rnd = carry ? mant_rnd[FRAC_W:1] : mant_rnd[FRAC_W-1:0];
    assign exp_rnd  = exp_q + EW'(carry);
    assign ovf      = !exp_rnd[EW-1] && (exp_rnd >= EW'(EMAX));
    assign unf      = exp_rnd[EW-1] || (exp_rnd == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            z_q         <= '0;
            flags_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            sign_q      <= 1'b0;
            rem_q       <= '0;
            quo_q       <= '0;
            mb_q        <= '0;
            exp_q       <= '0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b;
                        flags_q    <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= UNPACK;
                    end
                end
                UNPACK: begin
                    sign_q <= sign_d;
                    if (spec_hit) begin
                        z_q         <= spec_z;
                        flags_q     <= spec_f;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        rem_q   <= rem_init;
                        mb_q    <= mb_d;
                        exp_q   <= exp_d;
                        quo_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    rem_q <= rem_shift;
                    quo_q <= {quo_q[QW-2:0], rem_ge};
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(QW - 1)) state_q <= ROUND;
                end
                ROUND: begin
                    if (ovf)      z_q <= {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                    else if (unf) z_q <= {sign_q, {(EXP_W+FRAC_W){1'b0}}};
                    else          z_q <= {sign_q, exp_rnd[EXP_W-1:0], frac_rnd};
                    flags_q     <= {2'b00, ovf, unf};
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign output_z  = z_q;
    assign out_flags = flags_q;

endmodule

// File: tb/tb_fp_seq_divider.sv
// Directed bench for fp_seq_divider: scoreboard of expected results, latency and handshake checks.
module tb_fp_seq_divider;
    logic        clk = 1'b0;
    logic        rst, in_valid, out_ready;
    logic [31:0] a, b;
    logic        in_ready, out_valid;
    logic [31:0] output_z;
    logic [3:0]  out_flags;

    fp_seq_divider dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .output_z(output_z), .out_flags(out_flags)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] z;
        logic [3:0]  f;
    } exp_t;
    exp_t sb_q[$];

    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One full transaction: accept, wait for result, optionally stall the consumer, then handshake
    task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] ez, input logic [3:0] ef, input int lat,
                          input int hold, input bit poke);
        exp_t        e;
        int          n;
        bit          busy_ok, stable_ok;
        logic [31:0] z0;
        logic [3:0]  f0;
        e.z = ez;
        e.f = ef;
        sb_q.push_back(e);
        @(negedge clk);
        chk({tag, "/in_ready_idle"}, 32'(in_ready), 32'd1);
        a = av; b = bv; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0; a = '0; b = '0;
        n = 0;
        busy_ok = 1'b1;
        while (1) begin
            @(posedge clk);
            n++;
            #1;
            if (in_ready) busy_ok = 1'b0;
            if (poke && n == 5) begin
                in_valid = 1'b1; a = 32'h3F800000; b = 32'h3F800000;
            end
            if (poke && n == 6) in_valid = 1'b0;
            if (out_valid || n > 200) break;
        end
        chk({tag, "/latency"}, 32'(n), 32'(lat));
        chk({tag, "/busy"}, 32'(busy_ok), 32'd1);
        e = sb_q.pop_front();
        chk({tag, "/z"}, output_z, e.z);
        chk({tag, "/flags"}, 32'(out_flags), 32'(e.f));
        z0 = output_z;
        f0 = out_flags;
        stable_ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            if (output_z !== z0 || out_flags !== f0 || !out_valid || in_ready) stable_ok = 1'b0;
        end
        if (hold > 0) chk({tag, "/hold_stable"}, 32'(stable_ok), 32'd1);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk({tag, "/valid_drop"}, 32'(out_valid), 32'd0);
        chk({tag, "/ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset/in_ready", 32'(in_ready), 32'd1);
        chk("reset/out_valid", 32'(out_valid), 32'd0);
        chk("reset/z", output_z, 32'h0);
        chk("reset/flags", 32'(out_flags), 32'h0);
        rst = 1'b0;

        run_op("15div3",   32'h41700000, 32'h40400000, 32'h40A00000, 4'b0000, 28, 0, 1'b0);
        run_op("m35div7",  32'hC20C0000, 32'h40E00000, 32'hC0A00000, 4'b0000, 28, 5, 1'b0);
        run_op("1div3",    32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 28, 0, 1'b1);
        run_op("5div0",    32'h40A00000, 32'h00000000, 32'h7F800000, 4'b0100, 1,  0, 1'b0);
        run_op("0div0",    32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000, 1,  0, 1'b0);
        run_op("nan",      32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b1000, 1,  0, 1'b0);
        run_op("inf_inf",  32'h7F800000, 32'hFF800000, 32'h7FC00000, 4'b1000, 1,  0, 1'b0);
        run_op("inf_fin",  32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, 1,  0, 1'b0);
        run_op("fin_inf",  32'h40000000, 32'hFF800000, 32'h80000000, 4'b0000, 1,  0, 1'b0);
        run_op("overflow", 32'h7F000000, 32'h00800000, 32'h7F800000, 4'b0010, 28, 0, 1'b0);
        run_op("underflow",32'h00800000, 32'h40000000, 32'h00000000, 4'b0001, 28, 0, 1'b0);
        run_op("negzero",  32'h80000000, 32'h40000000, 32'h80000000, 4'b0000, 1,  0, 1'b0);
        run_op("6div1p5",  32'h40C00000, 32'h3FC00000, 32'h40800000, 4'b0000, 28, 0, 1'b0);

        // Abort in the middle of DIVIDE
        @(negedge clk);
        a = 32'h41700000; b = 32'h40400000; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (11) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort/out_valid", 32'(out_valid), 32'd0);
        chk("abort/in_ready", 32'(in_ready), 32'd1);
        @(negedge clk) rst = 1'b0;
        run_op("after_abort", 32'h41700000, 32'h40400000, 32'h40A00000, 4'b0000, 28, 0, 1'b0);

        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
